bcd_serial_addsub: RTL and testbench
====================================

Name: bcd_serial_addsub

Overview:
- Parametrised N-digit packed-BCD adder/subtractor that processes one decimal digit per clock, least significant digit first.
- Successor to the combinational two-digit BCD adder; adds a subtract mode with sign-magnitude result, input digit validation and a start/done handshake.
- Sits between the switch/operand registers and the bcd-to-seven-segment decoders on the board top level.

Parameters:
- DIGITS, 4, number of BCD digits per operand and result (>=1).
- CW, $clog2(DIGITS)+1, digit-counter width (derived, not overridden).

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- MODE  input  1  0 = A+B, 1 = A-B; latched with operands at START.
- A  input  4*DIGITS  packed BCD operand, digit 0 in [3:0].
- B  input  4*DIGITS  packed BCD operand.
- SUM  output  4*DIGITS  packed BCD result (magnitude in subtract mode).
- COUT  output  1  add: decimal carry out of the top digit; subtract: 0.
- NEG  output  1  subtract: result negative (A<B); add: 0.
- ERR  output  1  an operand digit was >9 at START.
- BUSY  output  1  high in ADD and FIX states.
- DONE  output  1  one-cycle pulse, result valid.

Behaviour:
- Reset (async, any state): state=IDLE; SUM=0, COUT=0, NEG=0, ERR=0, BUSY=0, DONE=0; operand and carry registers = 0.
- States: IDLE, ADD, FIX, DONE.
- IDLE, START=1:
  - Latch A, B and MODE; clear SUM, COUT, NEG and ERR.
  - If any digit of A or B is >9: ERR=1, SUM=0, go to DONE.
  - Otherwise: digit index=0; carry=MODE; operand Bx = MODE ? 9's complement of each B digit : B; go to ADD.
- ADD, per cycle (digit i):
  - s = A[i] + Bx[i] + carry (5-bit).
  - If s>9: SUM[i] = s-10 (4-bit), carry=1; else SUM[i]=s, carry=0.
  - After digit DIGITS-1:
    - MODE=0: COUT=carry, go to DONE.
    - MODE=1, carry=1: A>=B; NEG=0, COUT=0, go to DONE.
    - MODE=1, carry=0: result is 10's complement; NEG=1; index=0, carry=1; go to FIX.
- FIX, per cycle (digit i):
  - s = (9 - SUM[i]) + carry; apply the same >9 correction; write back to SUM[i].
  - After DIGITS cycles, go to DONE.
- DONE: DONE=1 for exactly one cycle, then IDLE.
- Outputs SUM, COUT, NEG and ERR hold until the next accepted START.
- Latency, counted from the START-sampling edge to the DONE-high cycle:
  - Add, or subtract with A>=B: DIGITS+1 edges.
  - Subtract with A<B: 2*DIGITS+1 edges.
  - Invalid digit: 1 edge.
- BUSY=1 exactly while in ADD or FIX.
- START outside IDLE (including during DONE) is ignored; changes to A, B or MODE after START have no effect on the running operation.
- Equal operands (A-B=0): carry=1 path; SUM=0, NEG=0 (no negative zero).
- Top-digit overflow in add wraps: SUM holds the low DIGITS digits and COUT=1.
- RESET asserted mid-operation aborts immediately; DONE is never pulsed for the aborted operation.
- The digit index never exceeds DIGITS-1; the last-digit compare uses DIGITS-1.

Test Plan (DIGITS=4):
1. Add 1234+8766, START one cycle -> SUM=0000, COUT=1, NEG=0, BUSY high 4 cycles, DONE 5 edges after START.
2. Add 9999+9999 -> SUM=9998, COUT=1; add 0000+0000 -> SUM=0000, COUT=0.
3. Subtract 5000-1234 -> SUM=3766, NEG=0, DONE after 5 edges. Subtract 1234-5000 -> SUM=3766, NEG=1, BUSY 8 cycles, DONE after 9 edges. Subtract 4321-4321 -> SUM=0000, NEG=0.
4. A=0x12A4, B=0x0001, START -> ERR=1, SUM=0000, DONE on next cycle, BUSY never high. A following valid START clears ERR.
5. START pulsed again and A changed during BUSY of 1111+2222 -> ignored; SUM=3333 with a single DONE pulse.
6. RESET asserted 2 cycles into 1234-5000 -> all outputs 0 and state IDLE immediately. A new START for 0005+0005 then gives SUM=0010, COUT=0.

Source files
------------

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result bundle for the serial BCD adder/subtractor.
// Handshake: the master holds START high for one cycle while A, B and MODE
// are valid; the slave samples them only while idle, raises BUSY while it
// works, and pulses DONE for one cycle when SUM/COUT/NEG/ERR are valid.
// Those result outputs hold until the next accepted START.
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  logic                  START;
  logic                  MODE;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic [4*DIGITS-1:0]   SUM;
  logic                  COUT;
  logic                  NEG;
  logic                  ERR;
  logic                  BUSY;
  logic                  DONE;
  logic [1:0]            STATE;   // debug view of the controller state

  modport master (
    output START, MODE, A, B,
    input  SUM, COUT, NEG, ERR, BUSY, DONE, STATE
  );

  modport slave (
    input  START, MODE, A, B,
    output SUM, COUT, NEG, ERR, BUSY, DONE, STATE
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Serial packed-BCD adder/subtractor, one decimal digit per clock, LSD first.
// Subtraction adds the 9's complement of B plus one; a missing final carry
// means A<B, and a second pass converts the 10's-complement result back to
// a magnitude so the output is always sign-magnitude.
module bcd_serial_addsub #(
  parameter  int DIGITS = 4,
  localparam int CW     = $clog2(DIGITS) + 1
) (
  input logic               CLOCK_50,
  input logic               RESET,
  bcd_serial_addsub_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_bx;
  logic [4*DIGITS-1:0] r_sum;
  logic                r_mode;
  logic                r_carry;
  logic                r_cout;
  logic                r_neg;
  logic                r_err;
  logic [CW-1:0]       r_idx;

  logic                w_bad;
  logic [4*DIGITS-1:0] w_bx_in;
  logic [3:0]          w_op_x;
  logic [3:0]          w_op_y;
  logic [4:0]          w_s;
  logic [4:0]          w_s_adj;
  logic                w_gt9;
  logic [3:0]          w_dig;
  logic                w_last;
  logic                w_busy;
  logic                w_done;

  // Flag any non-decimal operand digit and form the (possibly complemented) B
  always_comb begin
    w_bad   = 1'b0;
    w_bx_in = bus.B;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.A[4*i +: 4] > 4'd9 || bus.B[4*i +: 4] > 4'd9) w_bad = 1'b1;
      if (bus.MODE) w_bx_in[4*i +: 4] = 4'd9 - bus.B[4*i +: 4];
    end
  end

  // One decimal digit step shared by ADD (A+Bx) and FIX (9-SUM); both add carry
  always_comb begin
    w_op_x = r_a[4*int'(r_idx) +: 4];
    w_op_y = r_bx[4*int'(r_idx) +: 4];
    if (r_state == S_FIX) begin
      w_op_x = 4'd9 - r_sum[4*int'(r_idx) +: 4];
      w_op_y = 4'd0;
    end
    w_s     = {1'b0, w_op_x} + {1'b0, w_op_y} + {4'd0, r_carry};
    w_s_adj = w_s - 5'd10;
    w_gt9   = (w_s > 5'd9);
    w_dig   = w_gt9 ? w_s_adj[3:0] : w_s[3:0];
    w_last  = (r_idx == CW'(DIGITS - 1));
  end

  // State register
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.START) w_next = w_bad ? S_DONE : S_ADD;
      S_ADD:  if (w_last) w_next = (r_mode && !w_gt9) ? S_FIX : S_DONE;
      S_FIX:  if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_ADD, S_FIX: w_busy = 1'b1;
      S_DONE:       w_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch, digit write-back, carry, index and flags
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_a     <= '0;
      r_bx    <= '0;
      r_sum   <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_a     <= bus.A;
            r_bx    <= w_bx_in;
            r_mode  <= bus.MODE;
            r_carry <= bus.MODE;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_neg   <= 1'b0;
            r_err   <= w_bad;
          end
        end
        S_ADD: begin
          r_sum[4*int'(r_idx) +: 4] <= w_dig;
          if (!w_last) begin
            r_idx   <= r_idx + CW'(1);
            r_carry <= w_gt9;
          end else if (!r_mode) begin
            r_cout  <= w_gt9;
            r_carry <= w_gt9;
          end else if (!w_gt9) begin
            // No end-around carry: A<B, re-complement the result in FIX
            r_neg   <= 1'b1;
            r_idx   <= '0;
            r_carry <= 1'b1;
          end else begin
            r_carry <= w_gt9;
          end
        end
        S_FIX: begin
          r_sum[4*int'(r_idx) +: 4] <= w_dig;
          r_carry <= w_gt9;
          if (!w_last) r_idx <= r_idx + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.SUM   = r_sum;
  assign bus.COUT  = r_cout;
  assign bus.NEG   = r_neg;
  assign bus.ERR   = r_err;
  assign bus.BUSY  = w_busy;
  assign bus.DONE  = w_done;
  assign bus.STATE = r_state;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub with DIGITS=4.
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation; returns edges from START sampling to DONE and BUSY cycles seen
  task automatic run_op(input logic mode, input logic [15:0] a, input logic [15:0] b,
                        output int edges, output int busy_cnt);
    @(posedge clk);
    #1;
    bus.START = 1'b1;
    bus.MODE  = mode;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    edges     = 1;
    busy_cnt  = 0;
    while (bus.DONE !== 1'b1 && edges < 40) begin
      if (bus.BUSY === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
    if (bus.DONE !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: DONE not seen after %0d edges", edges);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.START = 1'b0;
    bus.MODE  = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.SUM, bus.COUT, bus.NEG, bus.ERR, bus.BUSY, bus.DONE, bus.STATE} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got sum=%h cout=%b neg=%b err=%b busy=%b done=%b st=%0d, want all 0",
               bus.SUM, bus.COUT, bus.NEG, bus.ERR, bus.BUSY, bus.DONE, bus.STATE);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    int e, bc;
    run_op(1'b0, 16'h1234, 16'h8766, e, bc);
    checks++;
    if ({bus.SUM, bus.COUT, bus.NEG} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_1234_8766: got sum=%h cout=%b neg=%b, want 0000 1 0", bus.SUM, bus.COUT, bus.NEG);
    end
    checks++;
    if (e !== 5 || bc !== 4) begin
      errors++;
      $display("FAIL add_latency: got edges=%0d busy=%0d, want 5 4", e, bc);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.DONE !== 1'b0 || bus.STATE !== 2'd0) begin
      errors++;
      $display("FAIL done_one_cycle: got done=%b state=%0d, want 0 0", bus.DONE, bus.STATE);
    end
    run_op(1'b0, 16'h9999, 16'h9999, e, bc);
    checks++;
    if ({bus.SUM, bus.COUT} !== {16'h9998, 1'b1}) begin
      errors++;
      $display("FAIL add_9999_9999: got sum=%h cout=%b, want 9998 1", bus.SUM, bus.COUT);
    end
    run_op(1'b0, 16'h0000, 16'h0000, e, bc);
    checks++;
    if ({bus.SUM, bus.COUT} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL add_0_0: got sum=%h cout=%b, want 0000 0", bus.SUM, bus.COUT);
    end
  endtask

  task automatic test_subtract();
    int e, bc;
    run_op(1'b1, 16'h5000, 16'h1234, e, bc);
    checks++;
    if ({bus.SUM, bus.NEG, bus.COUT} !== {16'h3766, 1'b0, 1'b0} || e !== 5) begin
      errors++;
      $display("FAIL sub_5000_1234: got sum=%h neg=%b cout=%b edges=%0d, want 3766 0 0 5",
               bus.SUM, bus.NEG, bus.COUT, e);
    end
    run_op(1'b1, 16'h1234, 16'h5000, e, bc);
    checks++;
    if ({bus.SUM, bus.NEG, bus.COUT} !== {16'h3766, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_1234_5000: got sum=%h neg=%b cout=%b, want 3766 1 0", bus.SUM, bus.NEG, bus.COUT);
    end
    checks++;
    if (e !== 9 || bc !== 8) begin
      errors++;
      $display("FAIL sub_neg_latency: got edges=%0d busy=%0d, want 9 8", e, bc);
    end
    run_op(1'b1, 16'h4321, 16'h4321, e, bc);
    checks++;
    if ({bus.SUM, bus.NEG, bus.COUT} !== {16'h0000, 1'b0, 1'b0} || e !== 5) begin
      errors++;
      $display("FAIL sub_equal: got sum=%h neg=%b cout=%b edges=%0d, want 0000 0 0 5",
               bus.SUM, bus.NEG, bus.COUT, e);
    end
    run_op(1'b1, 16'h0100, 16'h0001, e, bc);
    checks++;
    if ({bus.SUM, bus.NEG} !== {16'h0099, 1'b0}) begin
      errors++;
      $display("FAIL sub_0100_0001: got sum=%h neg=%b, want 0099 0", bus.SUM, bus.NEG);
    end
  endtask

  task automatic test_invalid_digit();
    int e, bc;
    run_op(1'b0, 16'h12A4, 16'h0001, e, bc);
    checks++;
    if ({bus.ERR, bus.SUM} !== {1'b1, 16'h0000} || e !== 1 || bc !== 0) begin
      errors++;
      $display("FAIL invalid_digit: got err=%b sum=%h edges=%0d busy=%0d, want 1 0000 1 0",
               bus.ERR, bus.SUM, e, bc);
    end
    run_op(1'b0, 16'h0001, 16'h0002, e, bc);
    checks++;
    if ({bus.ERR, bus.SUM} !== {1'b0, 16'h0003}) begin
      errors++;
      $display("FAIL err_cleared: got err=%b sum=%h, want 0 0003", bus.ERR, bus.SUM);
    end
  endtask

  task automatic test_start_during_busy();
    int dones;
    @(posedge clk);
    #1;
    bus.START = 1'b1;
    bus.MODE  = 1'b0;
    bus.A     = 16'h1111;
    bus.B     = 16'h2222;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    @(posedge clk);
    #1;
    bus.START = 1'b1;
    bus.A     = 16'h9999;
    bus.MODE  = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.DONE === 1'b1) begin
        dones++;
        checks++;
        if ({bus.SUM, bus.COUT, bus.NEG} !== {16'h3333, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL busy_ignore_sum: got sum=%h cout=%b neg=%b, want 3333 0 0",
                   bus.SUM, bus.COUT, bus.NEG);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL busy_ignore_done_count: got %0d DONE pulses, want 1", dones);
    end
  endtask

  task automatic test_reset_abort();
    int e, bc;
    int dones;
    @(posedge clk);
    #1;
    bus.START = 1'b1;
    bus.MODE  = 1'b1;
    bus.A     = 16'h1234;
    bus.B     = 16'h5000;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.SUM, bus.COUT, bus.NEG, bus.ERR, bus.BUSY, bus.DONE, bus.STATE} !== 23'd0) begin
      errors++;
      $display("FAIL reset_abort: got sum=%h cout=%b neg=%b err=%b busy=%b done=%b st=%0d, want all 0",
               bus.SUM, bus.COUT, bus.NEG, bus.ERR, bus.BUSY, bus.DONE, bus.STATE);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.DONE === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d DONE pulses, want 0", dones);
    end
    run_op(1'b0, 16'h0005, 16'h0005, e, bc);
    checks++;
    if ({bus.SUM, bus.COUT} !== {16'h0010, 1'b0} || e !== 5) begin
      errors++;
      $display("FAIL after_abort_add: got sum=%h cout=%b edges=%0d, want 0010 0 5", bus.SUM, bus.COUT, e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_subtract();
    test_invalid_digit();
    test_start_during_busy();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
